// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - command sequencer for an external combinational ALU
// Native ops take one ALU pass; MUL_OP runs a W-iteration shift-add loop.
module alu_mul_sequencer #(
  parameter int          W      = 8,
  parameter logic [3:0]  MUL_OP = 4'b1111
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         CmdValid,
  output logic         CmdReady,
  input  logic [3:0]   CmdOP,
  input  logic [W-1:0] CmdA,
  input  logic [W-1:0] CmdB,
  output logic         ResValid,
  input  logic         ResReady,
  output logic [W-1:0] Result,
  output logic         ResZero,
  output logic [W-1:0] AluInputA,
  output logic [W-1:0] AluInputB,
  output logic [3:0]   AluOP,
  input  logic [W-1:0] AluOut
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_TEST = 3'd2;
  localparam logic [2:0] S_ADD  = 3'd3;
  localparam logic [2:0] S_SHL  = 3'd4;
  localparam logic [2:0] S_SHR  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [3:0] OP_LSH = 4'b0000;
  localparam logic [3:0] OP_RSH = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b1011;

  logic [2:0]    state_q, state_d;
  logic [3:0]    opreg_q, opreg_d;
  logic [W-1:0]  areg_q, areg_d;
  logic [W-1:0]  breg_q, breg_d;
  logic [W-1:0]  p_q, p_d;
  logic          bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          reszero_q, reszero_d;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_op;

  always_comb begin
    state_d  = state_q;
    opreg_d  = opreg_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    p_d      = p_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OP_LSH;

    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          opreg_d = CmdOP;
          areg_d  = CmdA;
          breg_d  = CmdB;
          if (CmdOP == MUL_OP) begin
            p_d     = '0;
            cnt_d   = '0;
            state_d = S_TEST;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_a    = areg_q;
        alu_b    = breg_q;
        alu_op   = opreg_q;
        result_d = AluOut;
        state_d  = S_DONE;
      end
      S_TEST: begin
        alu_a   = breg_q;
        alu_b   = W'(1);
        alu_op  = OP_AND;
        bit_d   = AluOut[0];
        state_d = S_ADD;
      end
      S_ADD: begin
        alu_a   = p_q;
        alu_b   = bit_q ? areg_q : '0;
        alu_op  = OP_ADD;
        p_d     = AluOut;
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_a   = areg_q;
        alu_op  = OP_LSH;
        areg_d  = AluOut;
        state_d = S_SHR;
      end
      S_SHR: begin
        alu_a  = breg_q;
        alu_op = OP_RSH;
        breg_d = AluOut;
        // p_q already holds this iteration's sum; no early exit keeps latency fixed
        if (cnt_q == CNT_LAST) begin
          result_d = p_q;
          state_d  = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_TEST;
        end
      end
      S_DONE: begin
        if (ResReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    reszero_d = (result_d == '0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      opreg_q   <= '0;
      areg_q    <= '0;
      breg_q    <= '0;
      p_q       <= '0;
      bit_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      reszero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      opreg_q   <= opreg_d;
      areg_q    <= areg_d;
      breg_q    <= breg_d;
      p_q       <= p_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      reszero_q <= reszero_d;
    end
  end

  assign CmdReady  = (state_q == S_IDLE);
  assign ResValid  = (state_q == S_DONE);
  assign Result    = result_q;
  assign ResZero   = reszero_q;
  assign AluInputA = alu_a;
  assign AluInputB = alu_b;
  assign AluOP     = alu_op;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Command-side initiator for the shared combinational ALU: accepts an operation request over a valid/ready handshake, drives the ALU's InputA/InputB/OP, captures Out, and returns a registered result over a valid/ready handshake.
- Native ALU opcodes complete in one ALU pass.
- Pseudo-opcode MUL runs an 8-iteration shift-add loop built only from ALU ops (AND, ADD, LSH, RSH) and returns the low byte of A*B.
- Sits between the control unit and the ALU instance; the ALU itself is not instantiated inside.

Parameters:
- W, 8, data width (ALU operand width; loop count equals W).
- MUL_OP, 4'b1111, pseudo-opcode that selects the multiply sequence.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  synchronous, active-low reset.
- CmdValid  input  1  command request.
- CmdReady  output  1  block can accept a command.
- CmdOP  input  4  ALU opcode or MUL_OP.
- CmdA  input  W  operand A.
- CmdB  input  W  operand B.
- ResValid  output  1  result available.
- ResReady  input  1  consumer accepts result.
- Result  output  W  registered result.
- ResZero  output  1  Result == 0.
- AluInputA  output  W  to ALU InputA.
- AluInputB  output  W  to ALU InputB.
- AluOP  output  4  to ALU OP.
- AluOut  input  W  from ALU Out (combinational).

Behaviour:
- Reset (Reset_n low at a rising edge), all outputs and state:
  - state=IDLE, CmdReady=1, ResValid=0, Result=0, ResZero=1.
  - AluInputA=0, AluInputB=0, AluOP=4'b0000.
  - Internal regs P, Areg, Breg, Bit and Cnt all cleared.
- Reset mid-operation aborts the sequence; any in-flight result is discarded.
- States: IDLE, EXEC, TEST, ADD, SHL, SHR, DONE. Each non-IDLE/DONE state lasts exactly 1 cycle.
- CmdReady=1 only in IDLE. Accept = CmdValid && CmdReady at edge k. On accept, latch CmdOP/CmdA/CmdB into OPreg, Areg, Breg. CmdValid outside IDLE is ignored; the command is not queued.
- Native command (CmdOP != MUL_OP):
  - IDLE->EXEC.
  - In EXEC: AluInputA=Areg, AluInputB=Breg, AluOP=OPreg.
  - At edge k+1: Result<=AluOut, state->DONE.
  - Latency: 1 cycle.
  - Unlisted opcodes are forwarded unchanged; Result is whatever the ALU returns.
- MUL command:
  - On accept: P<=0, Cnt<=0, IDLE->TEST.
  - TEST: drive A=Breg, B=8'h01, OP=AND (0010); Bit<=AluOut[0]; ->ADD.
  - ADD: drive A=P, B=(Bit ? Areg : 8'h00), OP=ADD (1011); P<=AluOut; ->SHL.
  - SHL: drive A=Areg, OP=LSH (0000), B=8'h00; Areg<=AluOut; ->SHR.
  - SHR: drive A=Breg, OP=RSH (0001), B=8'h00; Breg<=AluOut.
    - If Cnt==W-1: Result<=P (value after this iteration's ADD), ->DONE.
    - Else: Cnt<=Cnt+1, ->TEST.
  - Fixed latency: 4*W = 32 cycles. ResValid is first high after edge k+32. There is no early exit when Breg==0.
  - Arithmetic is modulo 2^W: the ADD carry and bits shifted out are discarded, so Result = (A*B) mod 256.
- DONE:
  - ResValid=1; Result and ResZero are stable until the handshake completes.
  - ResValid && ResReady at an edge -> IDLE; CmdReady=1 the following cycle.
  - Back-to-back: a new command cannot be accepted in the same cycle the result is consumed.
- ResZero = (Result == 0). It is registered together with Result.
- Idle ALU drive: in IDLE and DONE, AluInputA=0, AluInputB=0, AluOP=4'b0000.
- Simultaneous CmdValid and Reset_n low: reset wins; the command is not accepted.

Test Plan:
- Reset_n=0 for 2 cycles, then release -> CmdReady=1, ResValid=0, Result=0x00, ResZero=1, AluOP=0000.
- Native ADD: CmdOP=1011, A=0x7F, B=0x01, accepted at edge k -> ResValid high after edge k+1, Result=0x80, ResZero=0. Repeat with NEQ, A=1, B=3 -> Result=0x01.
- MUL: CmdOP=1111, A=7, B=6 -> ResValid high exactly after edge k+32, Result=0x2A. A=0xFF, B=0xFF -> Result=0x01.
- MUL overflow: A=0x10, B=0x10 -> Result=0x00, ResZero=1. Monitor AluOP and check the repeating sequence AND, ADD, LSH, RSH for all 8 iterations.
- Backpressure and busy:
  - Hold ResReady=0 for 5 cycles after ResValid -> Result stays stable and no new command is accepted.
  - Pulse CmdValid mid-MUL with other operands -> command is ignored and Result is unchanged.
- Reset mid-MUL: assert Reset_n=0 at cycle k+10 -> next cycle shows state IDLE, ResValid=0, Result=0. A fresh MUL 3*5 then returns 0x0F at k'+32.
